// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control path.
// Contents: FSM state encoding, opcode constants, datapath mux-select
// encodings, the decoded control-word struct and small opcode helpers.
package riscv_ctrl_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_JAL      = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_NOP = 7'b0000000;

   localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
   localparam logic [SEL_W-1:0] RES_MEM     = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] IMM_I       = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S       = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B       = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J       = 2'b11;

   // Full control word produced by the output decoder for one state.
   typedef struct packed {
      logic             mem_req;
      logic             mem_write;
      logic             adr_src;
      logic             ir_write;
      logic             pc_write;
      logic             reg_write;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] alu_op;
      logic [SEL_W-1:0] imm_src;
      logic             instr_done;
      logic             halted;
   } ctrl_t;

   // Immediate format select, derived from the opcode alone.
   function automatic logic [SEL_W-1:0] imm_sel(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_SW:   imm_sel = IMM_S;
         OP_BEQ:  imm_sel = IMM_B;
         OP_JAL:  imm_sel = IMM_J;
         default: imm_sel = IMM_I;
      endcase
   endfunction

   // True for every opcode the controller sequences, including NOP.
   function automatic logic op_known(input logic [OPCODE_W-1:0] op);
      op_known = (op == OP_R)  || (op == OP_I)   || (op == OP_LW) ||
                 (op == OP_SW) || (op == OP_BEQ) || (op == OP_JAL) ||
                 (op == OP_NOP);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and datapath.
// master: controller side (consumes opcode/zero/mem_ready, drives controls).
// slave : datapath/memory side.
// Build option ILLEGAL_OP_TRAP_EN adds the sticky illegal_op status line.
interface multicycle_controller_if;
   import riscv_ctrl_pkg::*;

   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                mem_ready;
   logic                mem_req;
   logic                mem_write;
   logic                adr_src;
   logic                ir_write;
   logic                pc_write;
   logic                reg_write;
   logic [SEL_W-1:0]    result_src;
   logic [SEL_W-1:0]    alu_src_a;
   logic [SEL_W-1:0]    alu_src_b;
   logic [SEL_W-1:0]    alu_op;
   logic [SEL_W-1:0]    imm_src;
   logic                instr_done;
   logic                mem_timeout;
   logic                halted;
`ifdef ILLEGAL_OP_TRAP_EN
   logic                illegal_op;
`endif

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, imm_src,
             instr_done, mem_timeout, halted
`ifdef ILLEGAL_OP_TRAP_EN
      , output illegal_op
`endif
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             result_src, alu_src_a, alu_src_b, alu_op, imm_src,
             instr_done, mem_timeout, halted
`ifdef ILLEGAL_OP_TRAP_EN
      , input illegal_op
`endif
   );

endinterface

// File: rtl/ctrl_output_decoder.sv
// Combinational map from controller state (plus zero, mem_ready, opcode)
// to the full datapath control word.
// Ports: state, zero, mem_ready, opcode in; ctrl_c out.
// Build option ILLEGAL_OP_TRAP_EN: unknown opcodes retire nothing in DECODE.
module ctrl_output_decoder
   import riscv_ctrl_pkg::*;
(
   input  state_t              state,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic [OPCODE_W-1:0] opcode,
   output ctrl_t               ctrl_c
);

   // Per-state control word; everything not named in a state stays 0.
   always_comb begin
      ctrl_c         = '0;
      ctrl_c.imm_src = imm_sel(opcode);
      case (state)
         S_FETCH: begin
            ctrl_c.mem_req    = 1'b1;
            ctrl_c.alu_src_a  = SRCA_PC;
            ctrl_c.alu_src_b  = SRCB_FOUR;
            ctrl_c.alu_op     = ALUOP_ADD;
            ctrl_c.result_src = RES_ALU;
            ctrl_c.ir_write   = mem_ready;
            ctrl_c.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl_c.alu_src_a  = SRCA_OLDPC;
            ctrl_c.alu_src_b  = SRCB_IMM;
            ctrl_c.alu_op     = ALUOP_ADD;
`ifdef ILLEGAL_OP_TRAP_EN
            ctrl_c.instr_done = (opcode == OP_NOP);
`else
            ctrl_c.instr_done = (opcode == OP_NOP) || !op_known(opcode);
`endif
         end
         S_MEMADR: begin
            ctrl_c.alu_src_a  = SRCA_RS1;
            ctrl_c.alu_src_b  = SRCB_IMM;
            ctrl_c.alu_op     = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl_c.mem_req    = 1'b1;
            ctrl_c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            ctrl_c.result_src = RES_MEM;
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_c.mem_req    = 1'b1;
            ctrl_c.mem_write  = 1'b1;
            ctrl_c.adr_src    = 1'b1;
            ctrl_c.instr_done = mem_ready;
         end
         S_EXECR: begin
            ctrl_c.alu_src_a  = SRCA_RS1;
            ctrl_c.alu_src_b  = SRCB_RS2;
            ctrl_c.alu_op     = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ctrl_c.alu_src_a  = SRCA_RS1;
            ctrl_c.alu_src_b  = SRCB_IMM;
            ctrl_c.alu_op     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_c.result_src = RES_ALUOUT;
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl_c.alu_src_a  = SRCA_RS1;
            ctrl_c.alu_src_b  = SRCB_RS2;
            ctrl_c.alu_op     = ALUOP_SUB;
            ctrl_c.result_src = RES_ALUOUT;
            ctrl_c.pc_write   = zero;
            ctrl_c.instr_done = 1'b1;
         end
         S_JAL: begin
            // PC <= branch target from ALU-out; ALU forms old PC + 4 for rd.
            ctrl_c.alu_src_a  = SRCA_OLDPC;
            ctrl_c.alu_src_b  = SRCB_FOUR;
            ctrl_c.alu_op     = ALUOP_ADD;
            ctrl_c.result_src = RES_ALUOUT;
            ctrl_c.pc_write   = 1'b1;
         end
         S_HALT: begin
            ctrl_c        = '0;
            ctrl_c.halted = 1'b1;
         end
         default: ctrl_c.imm_src = imm_sel(opcode);
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared multicycle RISC-V datapath.
// Ports: clk, rst_n (async active-low), bus (multicycle_controller_if.master):
//   opcode/zero/mem_ready in; mem_req, mem_write, adr_src, ir_write, pc_write,
//   reg_write, result_src, alu_src_a/b, alu_op, imm_src, instr_done,
//   mem_timeout, halted out.
// Build option ILLEGAL_OP_TRAP_EN: unknown opcodes trap to HALT and set the
// sticky illegal_op output; otherwise they retire as NOPs.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TMO_W       = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_controller_if.master  bus
);

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_hit;
   logic             mem_timeout_q;
   ctrl_t            ctrl_c;
`ifdef ILLEGAL_OP_TRAP_EN
   logic             illegal_op_q;
   logic             illegal_set;
`endif

   ctrl_output_decoder u_dec (
      .state     (state_q),
      .zero      (bus.zero),
      .mem_ready (bus.mem_ready),
      .opcode    (bus.opcode),
      .ctrl_c    (ctrl_c)
   );

   // Stall counter: runs only while a request is outstanding and unanswered.
   always_comb begin
      tmo_cnt_d = '0;
      tmo_hit   = 1'b0;
      if ((MEM_TIMEOUT != 0) && ctrl_c.mem_req && !bus.mem_ready) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         tmo_hit   = (tmo_cnt_d == TMO_W'(MEM_TIMEOUT));
      end
   end

   // Next-state logic; a timeout overrides whatever the state would do.
   always_comb begin
      state_d = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_set = 1'b0;
`endif
      case (state_q)
         S_RESET:    state_d = S_FETCH;
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               OP_NOP:       state_d = S_FETCH;
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  state_d     = S_HALT;
                  illegal_set = 1'b1;
`else
                  state_d     = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR:   state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
         S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL:       state_d = S_ALUWB;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_HALT;
      endcase
      if (tmo_hit) state_d = S_HALT;
   end

   // State, stall counter and sticky status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RESET;
         tmo_cnt_q     <= '0;
         mem_timeout_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_op_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         if (tmo_hit) mem_timeout_q <= 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
         if (illegal_set) illegal_op_q <= 1'b1;
`endif
      end
   end

   assign bus.mem_req     = ctrl_c.mem_req;
   assign bus.mem_write   = ctrl_c.mem_write;
   assign bus.adr_src     = ctrl_c.adr_src;
   assign bus.ir_write    = ctrl_c.ir_write;
   assign bus.pc_write    = ctrl_c.pc_write;
   assign bus.reg_write   = ctrl_c.reg_write;
   assign bus.result_src  = ctrl_c.result_src;
   assign bus.alu_src_a   = ctrl_c.alu_src_a;
   assign bus.alu_src_b   = ctrl_c.alu_src_b;
   assign bus.alu_op      = ctrl_c.alu_op;
   assign bus.imm_src     = ctrl_c.imm_src;
   assign bus.instr_done  = ctrl_c.instr_done;
   assign bus.halted      = ctrl_c.halted;
   assign bus.mem_timeout = mem_timeout_q;
`ifdef ILLEGAL_OP_TRAP_EN
   assign bus.illegal_op  = illegal_op_q;
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory port, one instruction register.
- Replaces the single-cycle decode path. Supports lw, sw, R-type, I-type ALU, beq, jal and the all-zero NOP opcode.
- Handshakes with memory through mem_req/mem_ready.
- Produces datapath selects, write enables, a per-instruction retire pulse and error/halt status.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ready before halting; 0 disables the timeout.
- TMO_W, 8: width of the timeout counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]; registered in the datapath, valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store qualifier, valid with mem_req
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  load the IR and old-PC register
- pc_write  out  1  PC load enable
- reg_write  out  1  register-file write enable
- result_src  out  2  result mux: 00 = ALU-out register, 01 = memory data, 10 = ALU result
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  ALU B mux: 00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  to the ALU decoder: 00 = add, 01 = sub/compare, 10 = funct-decoded
- imm_src  out  2  combinational from opcode: I/lw 00, sw 01, beq 10, jal 11, others 00
- instr_done  out  1  one-cycle pulse when an instruction retires
- mem_timeout  out  1  sticky timeout flag
- halted  out  1  FSM is in HALT

Behaviour:
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- Reset (rst_n low, asynchronous): state RESET, timeout counter 0, mem_timeout 0.
  - In RESET every output is 0 except imm_src, which follows opcode.
  - RESET advances to FETCH unconditionally on the first clk edge after rst_n deasserts.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target computed into ALU-out). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0000000 -> FETCH with instr_done=1
  - any other opcode -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then instr_done=1 and -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=zero.
  - instr_done=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
- Memory handshake:
  - mem_req, adr_src and mem_write stay stable until the mem_ready cycle.
  - mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Timeout (when MEM_TIMEOUT != 0):
  - The counter increments each cycle mem_req=1 and mem_ready=0.
  - It clears on mem_ready or in any state with mem_req=0.
  - When the counter reaches MEM_TIMEOUT: next state HALT and mem_timeout is set.
  - If mem_ready=1 in the reaching cycle, mem_ready wins and there is no timeout.
- HALT: all outputs 0 except halted=1 and the sticky flags. Left only by reset.
- Reset mid-access drops mem_req immediately (asynchronous); no access is retried.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit, sticky, reset 0).
  - An unknown opcode in DECODE sets illegal_op and goes to HALT.
  - No instr_done is pulsed.
- Undefined:
  - The illegal_op port is absent.
  - An unknown opcode is treated as NOP: instr_done=1 and the next state is FETCH.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding constants (4 bits)
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_NOP
  - mux-select constants for result_src, alu_src_a, alu_src_b and alu_op
- Sub-module ctrl_output_decoder: purely combinational map from (state, zero, mem_ready, opcode) to all outputs.
- Next-state logic, timeout counter and sticky flags stay in multicycle_controller.

Test Plan:
- Reset, then mem_ready tied 1, opcode=0110011: states FETCH, DECODE, EXECR, ALUWB, FETCH.
  - reg_write=1 only in ALUWB.
  - instr_done pulses every 4 cycles.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD: mem_req/adr_src=1 held 4 cycles; MEMWB result_src=01, reg_write=1. Fetch-to-retire is 8 cycles.
- sw (0100011) with mem_ready=1: mem_write=1 for exactly one cycle with adr_src=1; reg_write never asserted; retires after 4 cycles.
- beq (1100011):
  - zero=1 -> pc_write=1 in BEQ.
  - zero=0 -> pc_write=0.
  - Both cases retire after 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: HALT entered after 4 cycles of mem_req; mem_timeout=1 and halted=1 until rst_n pulse. rst_n asserted mid-MEMREAD drops mem_req asynchronously.
- opcode=1111111:
  - With ILLEGAL_OP_TRAP_EN: illegal_op=1, halted=1.
  - Without: FETCH follows DECODE and instr_done=1.
